// File: rtl/alu_arbiter_pkg.sv
// Shared widths, opcodes, flag indices and FSM states
// for the two-requester ALU sequencer.
package alu_arbiter_pkg;

  localparam int OPSIZE   = 4;
  localparam int ALUWIDTH = 16;
  localparam int NUMFLAGS = 4;

  localparam logic [OPSIZE-1:0] OP_ADD = 4'd0;
  localparam logic [OPSIZE-1:0] OP_SUB = 4'd1;
  localparam logic [OPSIZE-1:0] OP_CMP = 4'd2;
  localparam logic [OPSIZE-1:0] OP_AND = 4'd3;
  localparam logic [OPSIZE-1:0] OP_OR  = 4'd4;
  localparam logic [OPSIZE-1:0] OP_LS  = 4'd5;
  localparam logic [OPSIZE-1:0] OP_RS  = 4'd6;

  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Two-way round-robin grant; the pointer names the
// requester that wins when both are valid.
module rr_arbiter2 (
  input  logic valid0,
  input  logic valid1,
  input  logic rr_ptr,
  output logic grant,
  output logic grant_id
);

  always_comb begin
    grant    = valid0 | valid1;
    grant_id = 1'b0;
    unique case (1'b1)
      (valid0 && valid1): grant_id = rr_ptr;
      (valid1 && !valid0): grant_id = 1'b1;
      default: grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two
// requesters and owns the {C V Z N} flag register.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [OPSIZE-1:0]   req0_opcode,
  input  logic [ALUWIDTH-1:0] req0_in1,
  input  logic [ALUWIDTH-1:0] req0_in2,
  input  logic                req0_setflags,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [OPSIZE-1:0]   req1_opcode,
  input  logic [ALUWIDTH-1:0] req1_in1,
  input  logic [ALUWIDTH-1:0] req1_in2,
  input  logic                req1_setflags,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_id,
  output logic [ALUWIDTH-1:0] resp_out,
  output logic [NUMFLAGS-1:0] resp_flags,
  output logic [NUMFLAGS-1:0] flags_q,
  output logic [OPSIZE-1:0]   alu_opcode,
  output logic [ALUWIDTH-1:0] alu_in1,
  output logic [ALUWIDTH-1:0] alu_in2,
  input  logic [ALUWIDTH-1:0] alu_out,
  input  logic [NUMFLAGS-1:0] alu_flags
);

  state_t r_state;
  state_t w_next;

  logic                r_rr;
  logic                r_id;
  logic                r_sf;
  logic [OPSIZE-1:0]   r_op;
  logic [ALUWIDTH-1:0] r_in1;
  logic [ALUWIDTH-1:0] r_in2;
  logic                r_rv;
  logic                r_rid;
  logic [ALUWIDTH-1:0] r_rout;
  logic [NUMFLAGS-1:0] r_rfl;
  logic [NUMFLAGS-1:0] r_flags;

  logic w_grant;
  logic w_gid;
  logic w_take;

  rr_arbiter2 u_arb (
    .valid0   (req0_valid),
    .valid1   (req1_valid),
    .rr_ptr   (r_rr),
    .grant    (w_grant),
    .grant_id (w_gid)
  );

  // Ready is masked during reset so no request is
  // acknowledged while the registers are being cleared.
  assign w_take = (r_state == ST_IDLE) && w_grant && !reset;

  assign req0_ready = w_take && !w_gid;
  assign req1_ready = w_take &&  w_gid;

  assign resp_valid = r_rv;
  assign resp_id    = r_rid;
  assign resp_out   = r_rout;
  assign resp_flags = r_rfl;
  assign flags_q    = r_flags;
  assign alu_opcode = r_op;
  assign alu_in1    = r_in1;
  assign alu_in2    = r_in2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_grant) w_next = ST_EXEC;
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: if (resp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr    <= 1'b0;
      r_id    <= 1'b0;
      r_sf    <= 1'b0;
      r_op    <= '0;
      r_in1   <= '0;
      r_in2   <= '0;
      r_rv    <= 1'b0;
      r_rid   <= 1'b0;
      r_rout  <= '0;
      r_rfl   <= '0;
      r_flags <= '0;
    end else begin
      if (w_take) begin
        r_op  <= w_gid ? req1_opcode   : req0_opcode;
        r_in1 <= w_gid ? req1_in1      : req0_in1;
        r_in2 <= w_gid ? req1_in2      : req0_in2;
        r_sf  <= w_gid ? req1_setflags : req0_setflags;
        r_id  <= w_gid;
        r_rr  <= ~w_gid;
      end
      if (r_state == ST_EXEC) begin
        r_rout <= alu_out;
        r_rfl  <= alu_flags;
        r_rid  <= r_id;
        r_rv   <= 1'b1;
        if (r_sf) r_flags <= alu_flags;
      end
      if (r_state == ST_RESP && resp_ready) r_rv <= 1'b0;
    end
  end

endmodule
